// File: rtl/koggestone_pkg.sv
// Shared widths, the generate/propagate pair type and the prefix combine
// operator used by the Kogge-Stone adder.
package koggestone_pkg;

  localparam int OP_W  = 4;
  localparam int ADD_W = 8;

  // Group generate/propagate pair carried through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Prefix operator: hi covers the more significant span, lo the span just
  // below it. Result covers the union of both spans.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

endpackage : koggestone_pkg

// File: rtl/ks_adder8.sv
// Purely combinational 8-bit Kogge-Stone parallel-prefix adder.
// Level 0 holds bit-level g/p, levels 1..3 combine with spans 1, 2 and 4.
module ks_adder8
  import koggestone_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = 3;

  // stage[l][i] is the group (G,P) over bits [i : max(0, i-2^l+1)],
  // with the carry-in folded into bit 0 so G always includes it.
  gp_t [ADD_W-1:0] stage [0:LEVELS];
  logic [ADD_W-1:0] prop;
  logic [ADD_W:0]   carry;

  assign prop = a ^ b;

  genvar lvl, bit_i;
  generate
    for (bit_i = 0; bit_i < ADD_W; bit_i++) begin : g_bit
      if (bit_i == 0) begin : g_lsb
        assign stage[0][bit_i].g = (a[bit_i] & b[bit_i]) | (prop[bit_i] & cin);
      end else begin : g_rest
        assign stage[0][bit_i].g = a[bit_i] & b[bit_i];
      end
      assign stage[0][bit_i].p = prop[bit_i];
    end

    for (lvl = 1; lvl <= LEVELS; lvl++) begin : g_level
      localparam int SPAN = 1 << (lvl - 1);
      for (bit_i = 0; bit_i < ADD_W; bit_i++) begin : g_node
        if (bit_i >= SPAN) begin : g_combine
          assign stage[lvl][bit_i] = gp_combine(stage[lvl-1][bit_i],
                                                stage[lvl-1][bit_i-SPAN]);
        end else begin : g_pass
          assign stage[lvl][bit_i] = stage[lvl-1][bit_i];
        end
      end
    end

    // Carry into bit i+1 is the full group generate G[i:0].
    assign carry[0] = cin;
    for (bit_i = 0; bit_i < ADD_W; bit_i++) begin : g_carry
      assign carry[bit_i+1] = stage[LEVELS][bit_i].g;
    end
  endgenerate

  assign sum  = prop ^ carry[ADD_W-1:0];
  assign cout = carry[ADD_W];

  // Final-level group propagates have no consumer in a carry-in adder.
  logic unused_prop;
  always_comb begin
    unused_prop = 1'b0;
    for (int i = 0; i < ADD_W; i++) unused_prop = unused_prop ^ stage[LEVELS][i].p;
  end

endmodule : ks_adder8

// File: rtl/koggestone_adder8.sv
// TinyTapeout slot: registered 4-bit + 4-bit add through an 8-bit
// Kogge-Stone adder. Bidirectional bank is unused and tied to input mode.
module koggestone_adder8
  import koggestone_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,   // active-high despite the harness name
  input  logic             ena,
  input  logic [ADD_W-1:0] ui_in,
  output logic [ADD_W-1:0] uo_out,
  input  logic [ADD_W-1:0] uio_in,
  output logic [ADD_W-1:0] uio_out,
  output logic [ADD_W-1:0] uio_oe
);

  logic [ADD_W-1:0] op_a;
  logic [ADD_W-1:0] op_b;
  logic [ADD_W-1:0] sum;
  logic             unused_cout;

  assign op_a = {{(ADD_W-OP_W){1'b0}}, ui_in[OP_W-1:0]};
  assign op_b = {{(ADD_W-OP_W){1'b0}}, ui_in[ADD_W-1:OP_W]};

  ks_adder8 u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (unused_cout)
  );

  // Output register: reset wins over enable, enable low holds the last sum.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst_n) begin
      uo_out <= '0;
    end else if (ena) begin
      uo_out <= sum;
    end
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

  // uio_in has no functional path; the reduction only keeps it referenced.
  logic unused_uio;
  assign unused_uio = ^uio_in;

endmodule : koggestone_adder8

// File: tb/tb_koggestone_adder8.sv
// Scoreboard bench for koggestone_adder8: a sampler pushes the expected
// register value at each rising edge, a monitor pops and compares at the
// following falling edge.
module tb_koggestone_adder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] value;
    string      tag;
  } exp_t;

  exp_t  sb_q[$];
  int    model = 0;
  string cur_tag = "reset";

  koggestone_adder8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: register value is plain integer a+b, cleared by reset,
  // frozen while enable is low.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n === 1'b1)   model = 0;
    else if (ena === 1'b1) model = int'(ui_in[3:0]) + int'(ui_in[7:4]);
    e.value = model[7:0];
    e.tag   = cur_tag;
    sb_q.push_back(e);
  end

  // Monitor: one result per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({"sb_", e.tag}, uo_out, e.value);
      check("uio_out_zero", uio_out, 8'h00);
      check("uio_oe_zero", uio_oe, 8'h00);
    end
  end

  task automatic drive(input logic r, input logic e, input logic [7:0] u, input string tag);
    @(negedge clk);
    rst_n   = r;
    ena     = e;
    ui_in   = u;
    uio_in  = 8'($urandom);
    cur_tag = tag;
  endtask

  // Directed check just after the edge that consumes the last drive.
  task automatic peek(input string name, input logic [7:0] expected);
    @(posedge clk);
    #1;
    check(name, uo_out, expected);
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'hFF;
    uio_in = 8'hA5;

    drive(1'b1, 1'b0, 8'hFF, "reset");       peek("reset_0", 8'h00);
    drive(1'b1, 1'b1, 8'hFF, "reset_ena");   peek("reset_over_ena", 8'h00);

    drive(1'b0, 1'b1, 8'h35, "basic");       peek("basic_5p3", 8'h08);
    drive(1'b0, 1'b1, 8'h00, "zero");        peek("zero", 8'h00);
    drive(1'b0, 1'b1, 8'h1F, "carry");       peek("carry_15p1", 8'h10);
    drive(1'b0, 1'b1, 8'hFF, "max");         peek("max_15p15", 8'h1E);

    drive(1'b0, 1'b1, 8'h35, "hold_load");   peek("hold_load", 8'h08);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'hFF, "hold");      peek("hold_ena0", 8'h08);
    end
    drive(1'b0, 1'b1, 8'hFF, "hold_release"); peek("hold_release", 8'h1E);

    drive(1'b1, 1'b1, 8'hFF, "mid_reset");   peek("mid_reset", 8'h00);
    drive(1'b0, 1'b1, 8'hFF, "post_reset");  peek("post_reset", 8'h1E);

    for (int v = 0; v < 256; v++) drive(1'b0, 1'b1, 8'(v), "exhaustive");

    for (int i = 0; i < 400; i++)
      drive(($urandom_range(15) == 0), ($urandom_range(3) != 0), 8'($urandom), "random");

    // Drain: after the monitor's pop the queue must be empty again.
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_koggestone_adder8

// File: doc/koggestone_adder8.md
# koggestone_adder8

Registered 4-bit + 4-bit adder for the TinyTapeout user-project slot. The two operands are packed on the dedicated input bus. They are zero-extended to 8 bits and summed by an 8-bit Kogge-Stone parallel-prefix adder. The result is presented on the dedicated output bus one clock later. The bidirectional IO bank is unused and permanently configured as input.

## Interface
- No parameters. Fixed widths: operand width 4, adder width 8.
- One clock; reset is synchronous and active-high. The ports keep the harness names `clk` / `rst_n`, and `rst_n` is sampled as active-high: 1 means reset.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-high reset.
- `ena` input 1: design enable; when 0, the output register holds.
- `ui_in` input 8: operand a = `ui_in[3:0]`, operand b = `ui_in[7:4]`.
- `uo_out` output 8: registered 8-bit sum of zero-extended a and b.
- `uio_in` input 8: ignored.
- `uio_out` output 8: constant 8'h00.
- `uio_oe` output 8: constant 8'h00, so all IO pins are inputs.

## Operation
- Operand extension: A = {4'b0, `ui_in[3:0]`}, B = {4'b0, `ui_in[7:4]`}, carry-in = 0.
- Kogge-Stone adder, 8 bits:
  - Per-bit generate g_i = A_i & B_i and propagate p_i = A_i ^ B_i.
  - Three prefix levels with spans 1, 2 and 4.
  - Combine operator: (G,P)∘(G',P') = (G | P&G', P&P').
  - Carry into bit i+1 is the group generate G[i:0]. Sum bit s_i = p_i ^ c_i, with c_0 = 0.
- Result S[7:0] = A + B, range 0..30. Bits [7:5] of the registered output are therefore always 0 and `uo_out[4]` is the 4-bit carry-out. The 8-bit carry-out G[7:0] is always 0 and is not exported.
- Register update on every rising `clk`, in priority order:
  - If `rst_n` = 1: `uo_out` ← 8'h00.
  - Else if `ena` = 1: `uo_out` ← S.
  - Else: `uo_out` holds.
- Reset takes priority over `ena`. A reset asserted mid-stream clears the output on that edge. The first post-reset result appears on the edge after reset is released.
- No X propagation from `uio_in`; it has no functional path.

## Timing
- Latency: one cycle. Operands sampled at edge N appear on `uo_out` after edge N. Throughput is one result per cycle.
- Combinational depth: bit-level g/p, then 3 prefix levels, then the sum XOR.
- Reset value: `uo_out` = 8'h00. `uio_out` and `uio_oe` are constant 0 in every cycle, including during reset.
- Operand change with `ena` = 0: no output change until `ena` returns to 1 at a rising edge.

## Structure
- Shared package `koggestone_pkg`:
  - `OP_W` = 4 and `ADD_W` = 8.
  - `gp_t` struct {g, p}.
  - Function `gp_combine` implementing the prefix operator.
- Sub-module `ks_adder8`: purely combinational 8-bit Kogge-Stone adder.
  - Inputs a[7:0], b[7:0], cin; outputs sum[7:0], cout.
  - Built as generate loops over levels and bits.
- Top module: operand unpack and zero-extension, `ks_adder8` instance, output register with reset/enable, and constant IO ties.

## Test plan
- Reset: hold `rst_n` = 1 for 2 cycles with `ui_in` = 8'hFF → `uo_out` = 8'h00. `uio_oe` = 8'h00 and `uio_out` = 8'h00 throughout.
- Basic add: `ena` = 1, `ui_in` = 8'h35 (a=5, b=3) → `uo_out` = 8'h08 one edge later. Then 8'h00 → 8'h00.
- Carry chain: `ui_in` = 8'h1F (a=15, b=1) → 8'h10. Then `ui_in` = 8'hFF → 8'h1E (maximum); bits [7:5] stay 0.
- Enable hold: load 8'h35 (→8'h08), drop `ena`, apply 8'hFF for 3 cycles → `uo_out` stays 8'h08. Raise `ena` → 8'h1E after the next edge.
- Reset mid-stream: with `uo_out` = 8'h1E, pulse `rst_n` = 1 for one edge while `ena` = 1 → 8'h00. Release → next edge shows the current sum.
- Exhaustive: all 256 `ui_in` values with `ena` = 1 → each `uo_out` equals a+b, checked one cycle after it is applied.
